sprite_ram_loader: RTL and testbench

//   Write side of the sprite bitmap memory that the orientation addresser reads.

---
 rtl/sprite_ram_loader_pkg.sv | 40 ++++
 rtl/sprite_ram_loader.sv | 126 ++++++++++++
 tb/tb_sprite_ram_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_ram_loader_pkg.sv
// Shared definitions for the sprite bitmap memory: stream framing constants,
// loader state encoding, header field layout and orientation codes.
package sprite_ram_loader_pkg;

    // Frame start marker on the host byte link
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Header byte layout: {rsv[7:5], fill[4], bitmap[3:0]}
    localparam int unsigned HDR_RSV_HI = 7;
    localparam int unsigned HDR_RSV_LO = 5;
    localparam int unsigned HDR_FILL   = 4;
    localparam int unsigned HDR_BMP_HI = 3;
    localparam int unsigned HDR_BMP_LO = 0;

    // Orientation code whose read order matches the loader's {bitmap, y, x} layout;
    // the remaining codes are interpreted by the orientation addresser.
    localparam logic [2:0] ORIENT_CANONICAL = 3'b011;

    // Loader frame parser states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_FVAL = 3'd3,
        S_FILL = 3'd4
    } state_e;

    function automatic logic [2:0] hdr_rsv(input logic [7:0] hdr);
        return hdr[HDR_RSV_HI:HDR_RSV_LO];
    endfunction

    function automatic logic hdr_fill(input logic [7:0] hdr);
        return hdr[HDR_FILL];
    endfunction

    function automatic logic [3:0] hdr_bmp(input logic [7:0] hdr);
        return hdr[HDR_BMP_HI:HDR_BMP_LO];
    endfunction

endpackage

// File: rtl/sprite_ram_loader.sv
// Write side of the sprite bitmap RAM: parses a framed byte stream
// (SYNC, header, payload) and writes one 16x16 bitmap at {bitmap, y, x},
// either from 256 payload bytes or by filling with a single value.
module sprite_ram_loader
    import sprite_ram_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic             px_clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [11:0]      wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             wr_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_e            state;
    logic [3:0]        bitmap;
    logic [7:0]        cnt;
    logic [PIX_W-1:0]  fill_val;
    logic [IDLE_W-1:0] idle_cnt;

    logic xfer;
    logic timed;
    logic timeout_hit;

    assign in_ready    = (state != S_FILL);
    assign busy        = (state != S_IDLE);
    assign xfer        = in_valid & in_ready;
    assign timed       = (state == S_HDR) || (state == S_DATA) || (state == S_FVAL);
    assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Frame parser, pixel/idle counters and registered RAM write port
    always_ff @(posedge px_clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bitmap   <= '0;
            cnt      <= '0;
            fill_val <= '0;
            idle_cnt <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;

            // Inter-byte watchdog; an accepting cycle always wins over expiry
            if (timed) begin
                if (xfer) begin
                    idle_cnt <= '0;
                end else if (timeout_hit) begin
                    idle_cnt <= '0;
                    err      <= 1'b1;
                    state    <= S_IDLE;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        if (hdr_rsv(in_data) != 3'b000) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            bitmap <= hdr_bmp(in_data);
                            cnt    <= '0;
                            state  <= hdr_fill(in_data) ? S_FVAL : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {bitmap, cnt};
                        wr_data <= in_data[PIX_W-1:0];
                        cnt     <= cnt + 8'd1;
                        if (cnt == 8'hFF) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_FVAL: begin
                    if (xfer) begin
                        fill_val <= in_data[PIX_W-1:0];
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {bitmap, cnt};
                    wr_data <= fill_val;
                    cnt     <= cnt + 8'd1;
                    if (cnt == 8'hFF) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Bench for sprite_ram_loader: frame-level reference model, per-cycle output
// comparison, RAM image comparison and hand-computed directed checks.
module tb_sprite_ram_loader;
    import sprite_ram_loader_pkg::*;

    localparam int unsigned TO = 50000;

    logic        px_clk   = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        err;

    sprite_ram_loader #(
        .SYNC_BYTE (8'hA5),
        .PIX_W     (8),
        .TIMEOUT   (TO)
    ) dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 px_clk = ~px_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM images: what the DUT wrote and what the model says should be written
    logic [7:0] dram [4096];
    logic [7:0] mram [4096];

    // Model state, in frame terms: pos 0 = hunting SYNC, 1 = expecting header,
    // 2.. = payload byte index + 2.
    bit          model_live = 1'b0;
    int          pos        = 0;
    bit          want_fill  = 1'b0;
    int          fill_left  = 0;
    int          idle       = 0;
    logic [3:0]  m_bmp      = 4'h0;
    logic [7:0]  m_fill     = 8'h00;
    logic        e_wr_en, e_done, e_err, e_busy, e_ready;
    logic [11:0] e_addr;
    logic [7:0]  e_data;

    task automatic m_write(input logic [3:0] b, input int idx, input logic [7:0] d);
        logic [7:0] i8;
        i8      = idx[7:0];
        e_wr_en = 1'b1;
        e_addr  = {b, i8};
        e_data  = d;
        mram[{b, i8}] = d;
        if (idx == 255) e_done = 1'b1;
    endtask

    // Reference model: advances one step per rising edge
    initial begin
        forever begin
            @(posedge px_clk);
            if (reset) begin
                model_live = 1'b1;
                pos = 0; want_fill = 1'b0; fill_left = 0; idle = 0;
                m_bmp = 4'h0; m_fill = 8'h00;
                e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
                e_addr = 12'h000; e_data = 8'h00; e_busy = 1'b0; e_ready = 1'b1;
            end else if (model_live) begin
                logic acc;
                acc = in_valid && e_ready;
                e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
                if (fill_left > 0) begin
                    m_write(m_bmp, 256 - fill_left, m_fill);
                    fill_left--;
                end else if (pos == 0) begin
                    if (acc && in_data == 8'hA5) begin
                        pos = 1; idle = 0;
                    end
                end else if (acc) begin
                    idle = 0;
                    if (pos == 1) begin
                        if (in_data[7:5] != 3'b000) begin
                            e_err = 1'b1; pos = 0;
                        end else begin
                            m_bmp = in_data[3:0]; want_fill = in_data[4]; pos = 2;
                        end
                    end else if (want_fill) begin
                        m_fill = in_data; fill_left = 256; pos = 0; want_fill = 1'b0;
                    end else begin
                        m_write(m_bmp, pos - 2, in_data);
                        pos++;
                        if (pos == 258) pos = 0;
                    end
                end else begin
                    idle++;
                    if (idle == int'(TO)) begin
                        e_err = 1'b1; pos = 0; idle = 0; want_fill = 1'b0;
                    end
                end
                e_busy  = (pos != 0) || (fill_left > 0);
                e_ready = (fill_left == 0);
            end
        end
    end

    int          n_wr = 0, n_done = 0, n_err = 0;
    logic [11:0] last_done_addr = 12'h000;

    // Per-cycle comparison of DUT outputs with the model, plus DUT RAM capture
    initial begin
        forever begin
            @(posedge px_clk);
            #2;
            if (model_live) begin
                chk("wr_en", 32'(wr_en), 32'(e_wr_en));
                chk("wr_addr", 32'(wr_addr), 32'(e_addr));
                chk("wr_data", 32'(wr_data), 32'(e_data));
                chk("done", 32'(done), 32'(e_done));
                chk("err", 32'(err), 32'(e_err));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("in_ready", 32'(in_ready), 32'(e_ready));
                if (wr_en === 1'b1) begin
                    dram[wr_addr] = wr_data;
                    n_wr++;
                end
                if (done === 1'b1) begin
                    n_done++;
                    last_done_addr = wr_addr;
                end
                if (err === 1'b1) n_err++;
            end
        end
    end

    // Present one byte from a falling edge and hold it until accepted
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int budget;
        in_data  = b;
        in_valid = 1'b1;
        budget   = 0;
        do begin
            ok = (in_ready === 1'b1);
            @(negedge px_clk);
            budget++;
        end while (!ok && budget < 2000);
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: byte %0h not accepted within %0d cycles", b, budget);
        end
    endtask

    function automatic logic [7:0] pat6(input int i);
        logic [7:0] v;
        v = 8'(i * 3 + 1);
        if (i % 7 == 0) v = 8'hA5;
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, e0, n, diffs;
        for (int i = 0; i < 4096; i++) begin
            dram[i] = 8'h00;
            mram[i] = 8'h00;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge px_clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        reset = 1'b0;
        @(negedge px_clk);

        // 1: bitmap 3 from a back-to-back payload
        w0 = n_wr; d0 = n_done;
        send_byte(8'hA5);
        send_byte(8'h03);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (i == 0) begin
                chk("t1_first_wr_en", 32'(wr_en), 32'd1);
                chk("t1_first_addr", 32'(wr_addr), 32'h300);
            end
        end
        chk("t1_done_now", 32'(done), 32'd1);
        chk("t1_done_addr_now", 32'(wr_addr), 32'h3FF);
        @(negedge px_clk);
        chk("t1_writes", 32'(n_wr - w0), 32'd256);
        chk("t1_dones", 32'(n_done - d0), 32'd1);
        chk("t1_last_done_addr", 32'(last_done_addr), 32'h3FF);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (dram[12'h300 + i] !== 8'(i)) diffs++;
        chk("t1_ram", 32'(diffs), 32'd0);

        // 2: fill bitmap 7 with 5A
        w0 = n_wr; d0 = n_done;
        send_byte(8'hA5);
        send_byte(8'h17);
        send_byte(8'h5A);
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge px_clk);
        end
        chk("t2_ready_low_cycles", 32'(n), 32'd256);
        @(negedge px_clk);
        chk("t2_writes", 32'(n_wr - w0), 32'd256);
        chk("t2_dones", 32'(n_done - d0), 32'd1);
        chk("t2_last_done_addr", 32'(last_done_addr), 32'h7FF);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (dram[12'h700 + i] !== 8'h5A) diffs++;
        chk("t2_ram", 32'(diffs), 32'd0);

        // 3: reserved header bits set, then a good frame on bitmap 2
        w0 = n_wr; e0 = n_err;
        send_byte(8'hA5);
        send_byte(8'hE2);
        chk("t3_err_pulse", 32'(err), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        @(negedge px_clk);
        chk("t3_err_clear", 32'(err), 32'd0);
        chk("t3_no_writes", 32'(n_wr - w0), 32'd0);
        chk("t3_errs", 32'(n_err - e0), 32'd1);
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h3C);
        @(negedge px_clk);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (dram[12'h200 + i] !== (8'(i) ^ 8'h3C)) diffs++;
        chk("t3_ram", 32'(diffs), 32'd0);

        // 4: stall inside the payload until the watchdog fires
        w0 = n_wr; d0 = n_done; e0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h40));
        n = 0;
        while (err !== 1'b1 && n < int'(TO) + 10) begin
            @(negedge px_clk);
            n++;
        end
        chk("t4_idle_to_err", 32'(n), 32'(TO));
        @(negedge px_clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_writes", 32'(n_wr - w0), 32'd10);
        chk("t4_dones", 32'(n_done - d0), 32'd0);
        chk("t4_errs", 32'(n_err - e0), 32'd1);
        diffs = 0;
        for (int i = 0; i < 10; i++) if (dram[12'h100 + i] !== 8'(i + 8'h40)) diffs++;
        if (dram[12'h10A] !== 8'h00) diffs++;
        chk("t4_ram", 32'(diffs), 32'd0);

        // 5: reset in the middle of a payload
        w0 = n_wr;
        send_byte(8'hA5);
        send_byte(8'h04);
        for (int i = 0; i < 100; i++) send_byte(8'(i) ^ 8'hFF);
        chk("t5_writes_before", 32'(n_wr - w0), 32'd100);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h22;
        @(negedge px_clk);
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        chk("t5_wr_addr", 32'(wr_addr), 32'd0);
        chk("t5_wr_data", 32'(wr_data), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done_err", 32'({done, err}), 32'd0);
        reset = 1'b0;
        w0 = n_wr;
        repeat (20) @(negedge px_clk);
        in_valid = 1'b0;
        chk("t5_no_writes_after", 32'(n_wr - w0), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        // 6: gapped payload on bitmap 5 containing SYNC values
        send_byte(8'hA5);
        send_byte(8'h05);
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge px_clk);
            send_byte(pat6(i));
        end
        @(negedge px_clk);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (dram[12'h500 + i] !== pat6(i)) diffs++;
        chk("t6_ram", 32'(diffs), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        // Whole-RAM agreement between DUT writes and model writes
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (dram[i] !== mram[i]) diffs++;
        chk("ram_all", 32'(diffs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
